// File: rtl/hazard_stall_unit_if.sv
// ID-stage hazard interface: pipeline status in, stall/flush controls and mul/div status out.
interface hazard_stall_unit_if;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RtAddr_i;
  logic        IDEX_MulDiv_i;
  logic [4:0]  IFID_RsAddr_i;
  logic [4:0]  IFID_RtAddr_i;
  logic        IFID_UsesRt_i;
  logic        IFID_HiLoUse_i;
  logic        Branch_taken_i;
  logic        PCWrite_o;
  logic        IFIDWrite_o;
  logic        IDEX_Bubble_o;
  logic        IFID_Flush_o;
  logic        md_busy_o;
  logic        md_done_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output IDEX_MemRead_i, IDEX_RtAddr_i, IDEX_MulDiv_i, IFID_RsAddr_i,
           IFID_RtAddr_i, IFID_UsesRt_i, IFID_HiLoUse_i, Branch_taken_i,
    input  PCWrite_o, IFIDWrite_o, IDEX_Bubble_o, IFID_Flush_o,
           md_busy_o, md_done_o, stall_cnt_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_RtAddr_i, IDEX_MulDiv_i, IFID_RsAddr_i,
           IFID_RtAddr_i, IFID_UsesRt_i, IFID_HiLoUse_i, Branch_taken_i,
    output PCWrite_o, IFIDWrite_o, IDEX_Bubble_o, IFID_Flush_o,
           md_busy_o, md_done_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush controller: load-use, HI/LO-vs-mul/div busy stalls, taken-branch flush.
// Optional stall-cycle performance counter enabled by STALL_PERF_CNT_EN.
module hazard_stall_unit #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = $clog2(MULDIV_LAT) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  hazard_stall_unit_if.slave   hz
);

  typedef enum logic {RUN, MD_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu, hl, stall;

  always_comb begin
    lu = hz.IDEX_MemRead_i && (hz.IDEX_RtAddr_i != 5'd0) &&
         ((hz.IDEX_RtAddr_i == hz.IFID_RsAddr_i) ||
          (hz.IFID_UsesRt_i && (hz.IDEX_RtAddr_i == hz.IFID_RtAddr_i)));
    hl = hz.IFID_HiLoUse_i &&
         ((state_q == MD_BUSY) || ((state_q == RUN) && hz.IDEX_MulDiv_i));
    stall = lu || hl;
  end

  assign hz.PCWrite_o     = !stall;
  assign hz.IFIDWrite_o   = !stall;
  assign hz.IDEX_Bubble_o = stall;
  // Stall wins over flush: branch operands are stale, so the branch re-resolves next cycle.
  assign hz.IFID_Flush_o  = hz.Branch_taken_i && !stall;
  assign hz.md_busy_o     = (state_q == MD_BUSY);
  assign hz.md_done_o     = (state_q == MD_BUSY) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (hz.IDEX_MulDiv_i) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_W'(MULDIV_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign hz.stall_cnt_o = stall_cnt_q;
`else
  assign hz.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized + directed bench for hazard_stall_unit with a queue-based scoreboard.
module tb_hazard_stall_unit;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_unit_if hzif ();

  hazard_stall_unit #(.MULDIV_LAT(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hzif.slave)
  );

  typedef struct packed {
    logic        chk;
    logic [5:0]  ctrl;   // PCWrite, IFIDWrite, Bubble, Flush, busy, done
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: remaining busy cycles of the mul/div unit and total stalled cycles.
  int unsigned busy_left = 0;
  longint unsigned stall_total = 0;
  bit          known = 1'b0;

  task automatic drive(input bit r, input bit mr, input int unsigned ex_rt, input bit md,
                       input int unsigned rs, input int unsigned rt, input bit ur,
                       input bit hilo, input bit br);
    exp_t e;
    bit busy, lu, hl, stall;
    @(posedge clk);
    #1;
    rst = r;
    hzif.IDEX_MemRead_i = mr;
    hzif.IDEX_RtAddr_i  = 5'(ex_rt);
    hzif.IDEX_MulDiv_i  = md;
    hzif.IFID_RsAddr_i  = 5'(rs);
    hzif.IFID_RtAddr_i  = 5'(rt);
    hzif.IFID_UsesRt_i  = ur;
    hzif.IFID_HiLoUse_i = hilo;
    hzif.Branch_taken_i = br;

    busy  = (busy_left > 0);
    lu    = mr && (ex_rt != 0) && ((ex_rt == rs) || (ur && ex_rt == rt));
    hl    = hilo && (busy || md);
    stall = lu || hl;
    e.chk  = known;
    e.ctrl = {~stall, ~stall, stall, br & ~stall, busy, busy_left == 1};
`ifdef STALL_PERF_CNT_EN
    e.cnt  = (stall_total > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(stall_total);
`else
    e.cnt  = 32'd0;
`endif
    q.push_back(e);

    // Effects of the coming clock edge
    if (r) begin
      busy_left   = 0;
      stall_total = 0;
      known       = 1'b1;
    end else begin
      if (stall) stall_total++;
      if (busy_left > 0) busy_left--;
      else if (md)       busy_left = LAT;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          act = {hzif.PCWrite_o, hzif.IFIDWrite_o, hzif.IDEX_Bubble_o,
                 hzif.IFID_Flush_o, hzif.md_busy_o, hzif.md_done_o};
          checks++;
          if (act !== e.ctrl) begin
            errors++;
            $display("FAIL ctrl t=%0t actual=%b required=%b", $time, act, e.ctrl);
          end
          checks++;
          if (hzif.stall_cnt_o !== e.cnt) begin
            errors++;
            $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, hzif.stall_cnt_o, e.cnt);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int unsigned waited;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // load-use on rs, then released
    drive(0, 1, 2, 0, 2, 0, 0, 0, 0);
    idle();
    // $zero destination, and rt match without UsesRt
    drive(0, 1, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 1, 5, 0, 1, 5, 0, 0, 0);
    drive(0, 1, 5, 0, 1, 5, 1, 0, 0);
    // mult followed by mflo: issue + LAT busy cycles stalled, then release
    drive(0, 0, 0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < int'(LAT); i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // branch blocked by load-use, then flushes
    drive(0, 1, 3, 0, 3, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // reset in the 2nd busy cycle aborts mul/div
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    // perf counter scenario: 3 load-use stalls + one HI/LO stall of LAT+1 cycles
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 7, 0, 1, 7, 1, 0, 0);
      idle();
    end
    drive(0, 0, 0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < int'(LAT); i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    idle();
    // random traffic over a small register range so matches are frequent
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(199) == 0, $urandom_range(2) == 0, $urandom_range(3),
            $urandom_range(7) == 0, $urandom_range(3), $urandom_range(3),
            $urandom_range(1) == 1, $urandom_range(2) == 0, $urandom_range(3) == 0);
    end
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- ID-stage stall/flush controller for the 5-stage MIPS pipeline; works alongside the EX-stage forwarding unit.
- Forwarding resolves hazards by bypass. This block handles the cases bypass cannot cover:
  - load-use hazards;
  - HI/LO dependencies on the multi-cycle mul/div unit;
  - taken-branch flush of IF/ID.
- Drives PC write enable, IF/ID write enable, the ID/EX control-bubble mux select and the IF/ID flush.

Parameters:
- MULDIV_LAT, 4, mul/div busy cycles after issue; legal range 1..16.
- CNT_W, $clog2(MULDIV_LAT)+1, width of the internal busy counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- IDEX_MemRead_i  in  1  instruction in ID/EX is a load
- IDEX_RtAddr_i  in  5  load destination register in ID/EX
- IDEX_MulDiv_i  in  1  instruction in ID/EX is mult/multu/div/divu
- IFID_RsAddr_i  in  5  rs of the instruction in ID
- IFID_RtAddr_i  in  5  rt of the instruction in ID
- IFID_UsesRt_i  in  1  ID instruction reads rt as a source
- IFID_HiLoUse_i  in  1  ID instruction is mul/div/mfhi/mflo/mthi/mtlo
- Branch_taken_i  in  1  branch in ID resolved taken
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID register load enable
- IDEX_Bubble_o  out  1  1 = zero ID/EX control fields (insert bubble)
- IFID_Flush_o  out  1  clear IF/ID to NOP
- md_busy_o  out  1  mul/div unit busy
- md_done_o  out  1  last busy cycle; HI/LO written at the following edge
- stall_cnt_o  out  32  stall-cycle count (see Optional Feature)

Behaviour:
- Reset, synchronous on rst_i:
  - state=RUN, cnt=0, stall_cnt=0.
  - Resulting outputs: PCWrite_o=1, IFIDWrite_o=1, IDEX_Bubble_o=0, IFID_Flush_o=0, md_busy_o=0, md_done_o=0.
  - rst_i during MD_BUSY aborts the operation: md_done_o is never pulsed.
- Internal load-use term `lu`:
  - lu = IDEX_MemRead_i && IDEX_RtAddr_i!=0 && (IDEX_RtAddr_i==IFID_RsAddr_i || (IFID_UsesRt_i && IDEX_RtAddr_i==IFID_RtAddr_i)).
- Internal HI/LO term `hl`:
  - hl = IFID_HiLoUse_i && (state==MD_BUSY || (state==RUN && IDEX_MulDiv_i)).
- stall = lu || hl. All stall outputs are combinational, same cycle:
  - PCWrite_o=!stall, IFIDWrite_o=!stall, IDEX_Bubble_o=stall.
- Flush:
  - IFID_Flush_o = Branch_taken_i && !stall. A stall has priority because the branch operands are not yet valid; the branch re-evaluates next cycle.
- Load-use is exactly one stall cycle:
  - The bubble clears IDEX_MemRead_i on the next cycle.
  - The loaded value then reaches the consumer via MEM/WB forwarding.
- FSM, states RUN and MD_BUSY:
  - RUN, IDEX_MulDiv_i=1 at edge: move to MD_BUSY, cnt<=MULDIV_LAT-1.
  - MD_BUSY, cnt!=0: cnt<=cnt-1.
  - MD_BUSY, cnt==0: move to RUN.
  - md_busy_o = (state==MD_BUSY).
  - md_done_o = (state==MD_BUSY && cnt==0), combinational, one cycle.
- Busy window and release:
  - Busy lasts exactly MULDIV_LAT cycles. With MULDIV_LAT=1 there is a single busy cycle, and md_done_o rises in that cycle.
  - A HiLoUse instruction stalls in every busy cycle, including the md_done_o cycle.
  - It is released in the first RUN cycle and reads the updated HI/LO.
- Decoder contract: a second mul/div cannot issue while busy, because the decoder must assert IFID_HiLoUse_i for every mul/div. IDEX_MulDiv_i seen while already in MD_BUSY is ignored.
- Simultaneous events:
  - lu and hl together: one combined stall; both conditions re-evaluate next cycle.
  - Mul/div issue with a load-use on the next instruction: independent; the FSM still advances.
- Register $zero as load destination never stalls.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments on every clock with PCWrite_o==0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst_i.
- Undefined: stall_cnt_o is tied to 0 and no counter flop is built. The port list is unchanged.

Test Plan:
- lw $2 in ID/EX (IDEX_MemRead_i=1, IDEX_RtAddr_i=2), ID reads rs=2 -> one cycle with PCWrite_o=0, IFIDWrite_o=0, IDEX_Bubble_o=1; next cycle all released.
- Load to $0 with rs=0; and load to $5 with rt=5, IFID_UsesRt_i=0 -> no stall in either case.
- MULDIV_LAT=4: mult in ID/EX, mflo in ID -> stall in the issue cycle plus 4 busy cycles (5 total); md_done_o high in the 4th busy cycle; mflo issues in the 6th cycle.
- Branch_taken_i=1 with lu=1 -> IFID_Flush_o=0 and stall=1; next cycle Branch_taken_i=1, lu=0 -> IFID_Flush_o=1, PCWrite_o=1.
- rst_i asserted in the 2nd busy cycle -> next cycle md_busy_o=0, PCWrite_o=1, md_done_o never asserted; a subsequent mflo is not stalled.
- STALL_PERF_CNT_EN defined, 3 load-use stalls plus one 5-cycle HI/LO stall -> stall_cnt_o=8. Undefined -> stall_cnt_o=0.
